// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample, result and coefficient-write handshake bundle for the folded FIR
//
// Purpose : groups the three valid/ready style channels of fir_mac_sequencer.
// Signals : s_valid/s_ready/s_data       sample input channel
//           m_valid/m_ready/m_data       filtered result output channel
//           cfg_we/cfg_ready/cfg_addr/cfg_data  coefficient write channel
// Modports: master = sample source / result sink / config master side
//           slave  = filter side
interface fir_mac_sequencer_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic        [DW-1:0] m_data;
  logic                 cfg_we;
  logic                 cfg_ready;
  logic        [3:0]    cfg_addr;
  logic signed [CW-1:0] cfg_data;

  modport master (
    output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
    input  s_ready, m_valid, m_data, cfg_ready
  );

  modport slave (
    input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
    output s_ready, m_valid, m_data, cfg_ready
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - folded time-multiplexed symmetric FIR with one pre-adder and one multiplier
//
// Purpose : accepts a sample, runs NPAIR multiply-accumulate cycles over symmetric
//           tap pairs, and returns a shifted, saturated result. Owns a writable
//           coefficient bank shared with the sample path under one controller.
// Ports   : clk      clock, rising edge
//           n_rst    asynchronous active-low reset
//           bus      fir_mac_sequencer_if.slave (sample in, result out, coefficient write)
//           busy     high whenever the controller is not idle
//           ovf      sticky saturation flag
//           ovf_clr  clears ovf (a same-cycle saturation wins)
module fir_mac_sequencer #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAP  = 20,
  parameter int SHIFT = 7,
  parameter int ACC_W = 21
) (
  input  logic                  clk,
  input  logic                  n_rst,
  fir_mac_sequencer_if.slave    bus,
  output logic                  busy,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int NPAIR = NTAP / 2;
  localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int IW    = (NTAP > 1) ? $clog2(NTAP) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Power-on lowpass coefficients; only defined for the 20-tap build.
  function automatic logic signed [CW-1:0] h_default(input int idx);
    logic [7:0] v;
    v = 8'h00;
    if (NTAP == 20) begin
      case (idx)
        0: v = 8'h0A;
        1: v = 8'h00;
        2: v = 8'hF2;
        3: v = 8'hE8;
        4: v = 8'hEB;
        5: v = 8'h00;
        6: v = 8'h25;
        7: v = 8'h50;
        8: v = 8'h72;
        9: v = 8'h7F;
        default: v = 8'h00;
      endcase
    end
    return CW'(signed'(v));
  endfunction

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    d_q [NTAP];
  logic signed [CW-1:0]    h_q [NPAIR];
  logic signed [ACC_W-1:0] acc_q;
  logic [KW-1:0]           k_q;
  logic                    m_valid_q;
  logic [DW-1:0]           m_data_q;
  logic                    ovf_q;

  logic                    accept;
  logic                    cfg_wr;
  logic                    mac_last;
  logic                    out_done;
  logic [IW-1:0]           near_idx;
  logic [IW-1:0]           mir_idx;
  logic signed [DW:0]      pre_add;
  logic signed [DW+CW:0]   prod;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_shift;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [DW-1:0]           sat_val;

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cfg_wr   = 1'b0;
    mac_last = 1'b0;
    out_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A coefficient write takes the cycle; the sample waits.
        cfg_wr = bus.cfg_we;
        accept = bus.s_valid && !bus.cfg_we;
        if (accept) state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == KW'(NPAIR - 1)) begin
          mac_last = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          out_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.s_ready   = (state_q == S_IDLE) && !bus.cfg_we;
  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign busy          = (state_q != S_IDLE);
  assign ovf           = ovf_q;

  // Pair k folds tap k with its mirror tap NTAP-1-k before the single multiply.
  always_comb begin
    near_idx  = IW'(k_q);
    mir_idx   = IW'(NTAP - 1) - IW'(k_q);
    pre_add   = (DW + 1)'(d_q[near_idx]) + (DW + 1)'(d_q[mir_idx]);
    prod      = (DW + CW + 1)'(pre_add) * (DW + CW + 1)'(h_q[k_q]);
    acc_next  = acc_q + ACC_W'(prod);
    acc_shift = acc_next >>> SHIFT;
    sat_hi    = (acc_shift > SAT_MAX);
    sat_lo    = (acc_shift < SAT_MIN);
    if (sat_hi)      sat_val = SAT_MAX[DW-1:0];
    else if (sat_lo) sat_val = SAT_MIN[DW-1:0];
    else             sat_val = acc_shift[DW-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NTAP; i++) d_q[i] <= '0;
      for (int j = 0; j < NPAIR; j++) h_q[j] <= h_default(j);
      acc_q     <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        d_q[0] <= bus.s_data;
        for (int i = 1; i < NTAP; i++) d_q[i] <= d_q[i-1];
        acc_q <= '0;
        k_q   <= '0;
      end

      // Out-of-range addresses are acknowledged but write nothing.
      if (cfg_wr && (32'(bus.cfg_addr) < NPAIR)) h_q[bus.cfg_addr[KW-1:0]] <= bus.cfg_data;

      if (state_q == S_MAC) begin
        acc_q <= acc_next;
        if (!mac_last) k_q <= k_q + 1'b1;
      end

      if (mac_last) begin
        m_data_q  <= sat_val;
        m_valid_q <= 1'b1;
      end else if (out_done) begin
        m_valid_q <= 1'b0;
      end

      if (mac_last && (sat_hi || sat_lo)) ovf_q <= 1'b1;
      else if (ovf_clr)                   ovf_q <= 1'b0;
    end
  end

endmodule
